// File: rtl/sub_rr_scheduler.sv
// Round-robin share of one subtractor (D = A - B) among N_REQ requesters; accept at edge T, result valid after T+1.
// Backpressure: result held in RESP until res_ready; req_ready stays low until the result is consumed.
module sub_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int OP_W  = 4,
  parameter int RES_W = 8,
  parameter int ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*OP_W-1:0]   req_a,
  input  logic [N_REQ*OP_W-1:0]   req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RES_W-1:0]        res_data,
  output logic [ID_W-1:0]         res_id,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;

  logic [2*N_REQ-1:0] valid_dbl;
  logic [2*N_REQ-1:0] valid_rot;
  logic [ID_W:0]      sum;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_id;
  logic [RES_W-1:0]   diff;

  // Rotate the request vector so rr_ptr sits at bit 0; the lowest set bit is the winner.
  always_comb begin
    valid_dbl = {req_valid, req_valid};
    valid_rot = valid_dbl >> rr_ptr_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    sum       = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (valid_rot[k]) begin
        sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(N_REQ)) begin
          sum = sum - (ID_W+1)'(N_REQ);
        end
        grant_vld = 1'b1;
        grant_id  = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && grant_vld) begin
      req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;
    end
  end

  // The single shared subtractor, fed only from the latched operand registers.
  assign diff = {{(RES_W-OP_W){1'b0}}, a_q} - {{(RES_W-OP_W){1'b0}}, b_q};

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
              a_d = req_a[i*OP_W +: OP_W];
              b_d = req_b[i*OP_W +: OP_W];
            end
          end
          id_d    = grant_id;
          state_d = EXEC;
          busy_d  = 1'b1;
        end
      end
      EXEC: begin
        res_data_d  = diff;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sub_rr_scheduler.sv
// Bench for sub_rr_scheduler: directed and random transactions checked against a round-robin reference model.
module tb_sub_rr_scheduler;
  localparam int N  = 4;
  localparam int OW = 4;
  localparam int RW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*OW-1:0] req_a = '0;
  logic [N*OW-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [RW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic            busy;

  int checks = 0;
  int failures = 0;
  int ptr = 0;
  int last_w = 0;
  time acc_t = 0;
  time prev_t = 0;
  logic [OW-1:0] a_v [N];
  logic [OW-1:0] b_v [N];
  logic [N-1:0]  vmask = '0;
  logic [N-1:0]  newbits;

  sub_rr_scheduler #(.N_REQ(N), .OP_W(OW), .RES_W(RW), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbiter: first valid requester at or after ptr, going upward modulo N.
  function automatic int ref_winner(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) begin
      if (((m >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_a[i*OW +: OW] = a_v[i];
      req_b[i*OW +: OW] = b_v[i];
    end
    req_valid = vmask;
  endtask

  task automatic check_zero(input string t);
    chk({t, "_res_valid"}, res_valid, 0);
    chk({t, "_req_ready"}, req_ready, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_res_data"}, res_data, 0);
    chk({t, "_res_id"}, res_id, 0);
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge back in idle.
  task automatic txn(input int hold, input bit keep);
    int w;
    logic [RW-1:0] ed;
    drive();
    #1;
    w = ref_winner(vmask, ptr);
    chk("grant", req_ready, 32'(1) << w);
    chk("idle_busy", busy, 0);
    ed = RW'(int'(a_v[w]) - int'(b_v[w]));
    @(posedge clk);
    acc_t = $time;
    @(negedge clk);
    chk("exec_ready", req_ready, 0);
    chk("exec_busy", busy, 1);
    chk("exec_res_valid", res_valid, 0);
    if (keep) begin
      a_v[w] = OW'($urandom_range(15));
      b_v[w] = OW'($urandom_range(15));
    end else begin
      vmask[w] = 1'b0;
    end
    drive();
    res_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    chk("resp_valid", res_valid, 1);
    chk("resp_data", res_data, ed);
    chk("resp_id", res_id, w);
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, ed);
      chk("hold_id", res_id, w);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    ptr = (w + 1) % N;
    last_w = w;
    @(negedge clk);
    chk("done_valid", res_valid, 0);
    chk("done_busy", busy, 0);
    res_ready = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (2) @(negedge clk);
    check_zero("por");
    rst_n = 1'b1;

    // Nothing requested: no grant, stays idle.
    vmask = '0;
    drive();
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", req_ready, 0);
      chk("idle_busy0", busy, 0);
    end

    // Basic transaction and arithmetic edge cases.
    a_v[0] = 4'd5;  b_v[0] = 4'd2;  vmask = 4'b0001; txn(0, 0);
    chk("t1_data", res_data, 8'h03);
    a_v[1] = 4'd2;  b_v[1] = 4'd5;  vmask = 4'b0010; txn(0, 0);
    chk("t2_data", res_data, 8'hFD);
    a_v[2] = 4'd0;  b_v[2] = 4'd15; vmask = 4'b0100; txn(0, 0);
    chk("t2_min", res_data, 8'hF1);
    a_v[3] = 4'd15; b_v[3] = 4'd0;  vmask = 4'b1000; txn(0, 0);
    chk("t2_max", res_data, 8'h0F);
    a_v[0] = 4'd9;  b_v[0] = 4'd9;  vmask = 4'b0001; txn(0, 0);
    chk("t2_zero", res_data, 8'h00);

    // All requesters continuously valid from reset: strict rotation, one accept per 3 cycles.
    reset_dut();
    for (int i = 0; i < N; i++) begin
      a_v[i] = OW'($urandom_range(15));
      b_v[i] = OW'($urandom_range(15));
    end
    vmask = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      txn(0, 1);
      chk("rr_order", last_w, i % N);
      if (i > 0) chk("spacing", 32'(acc_t - prev_t), 30);
      prev_t = acc_t;
    end

    // Consumer stalls in RESP while others keep requesting.
    txn(5, 1);
    vmask = '0;

    // Reset during EXEC discards the operation; requester 2 is re-granted afterwards.
    reset_dut();
    a_v[2] = 4'd7; b_v[2] = 4'd1; vmask = 4'b0100;
    drive();
    @(posedge clk);
    @(negedge clk);
    chk("t5_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    txn(0, 0);
    chk("t5_data", res_data, 8'h06);
    chk("t5_id", res_id, 2);

    // Only requester 3; pointer wraps to 0 after each, so requester 0 wins next.
    repeat (3) begin
      a_v[3] = OW'($urandom_range(15));
      b_v[3] = OW'($urandom_range(15));
      vmask = 4'b1000;
      txn(0, 0);
      chk("t6_id", res_id, 3);
    end
    a_v[0] = 4'd4; b_v[0] = 4'd1; vmask = 4'b1001;
    txn(0, 0);
    chk("t6_wrap", res_id, 0);
    vmask = '0;

    // Random traffic: pending requesters hold until granted, new ones join randomly.
    for (int n = 0; n < 24; n++) begin
      newbits = N'($urandom_range(15)) & ~vmask;
      for (int i = 0; i < N; i++) begin
        if (newbits[i]) begin
          a_v[i] = OW'($urandom_range(15));
          b_v[i] = OW'($urandom_range(15));
        end
      end
      vmask = vmask | newbits;
      if (vmask == '0) begin
        vmask = 4'b0100;
        a_v[2] = OW'($urandom_range(15));
        b_v[2] = OW'($urandom_range(15));
      end
      txn($urandom_range(2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
